// File: rtl/ifu_fetch_pkg.sv
`default_nettype none
// ============================================================================
// ifu_fetch_pkg : widths, vector bit indices and fetch-queue entry type
// Rev 1.0
// ============================================================================
package ifu_fetch_pkg;

   localparam int RV32_DATA_WIDTH = 32;
   localparam int STALL_VEC_WIDTH = 2;
   localparam int FLUSH_VEC_WIDTH = 2;

   localparam int STALL_PC_BIT   = 0;
   localparam int STALL_IFID_BIT = 1;
   localparam int FLUSH_IFID_BIT = 1;

   localparam logic [RV32_DATA_WIDTH-1:0] NOP_INSN = 32'h0000_0013;

   typedef struct packed {
      logic [RV32_DATA_WIDTH-1:0] pc;
      logic [RV32_DATA_WIDTH-1:0] insn;
   } fetch_entry_t;

   localparam int ENTRY_WIDTH = $bits(fetch_entry_t);

endpackage
`default_nettype wire

// File: rtl/ifu_queue.sv
`default_nettype none
// ============================================================================
// ifu_queue : synchronous FIFO with push/pop/clear, count and full/empty flags
// Rev 1.0
// ============================================================================
module ifu_queue
   import ifu_fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int WIDTH = ENTRY_WIDTH
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic                     i_clear,
   input  logic [WIDTH-1:0]         i_wdata,
   output logic [WIDTH-1:0]         o_rdata,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_rdata = r_mem[r_rd_ptr];

   // A push into a full queue is accepted only when a pop frees a slot in the same cycle
   assign w_pop  = i_pop & ~o_empty;
   assign w_push = i_push & (~o_full | w_pop);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push && !i_clear) r_mem[r_wr_ptr] <= i_wdata;
   end

endmodule
`default_nettype wire

// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// ifu_fetch : PC generation, single-outstanding ibus fetch, fetch queue, IF/ID
// Rev 1.0
// ============================================================================
module ifu_fetch
   import ifu_fetch_pkg::*;
#(
   parameter logic [RV32_DATA_WIDTH-1:0] RESET_PC    = 32'h0000_0000,
   parameter int                         QUEUE_DEPTH = 2
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic [STALL_VEC_WIDTH-1:0] i_stall_vec,
   input  logic [FLUSH_VEC_WIDTH-1:0] i_flush_vec,
   input  logic                       i_x_branch_taken,
   input  logic [RV32_DATA_WIDTH-1:0] i_x_branch_target,
   input  logic                       i_clint_assert,
   input  logic [RV32_DATA_WIDTH-1:0] i_clint_addr,
   output logic                       o_ibus_req,
   output logic [RV32_DATA_WIDTH-1:0] o_ibus_addr,
   input  logic                       i_ibus_gnt,
   input  logic                       i_ibus_rvalid,
   input  logic [RV32_DATA_WIDTH-1:0] i_ibus_rdata,
   output logic                       o_if_vld,
   output logic [RV32_DATA_WIDTH-1:0] o_if_pc,
   output logic [RV32_DATA_WIDTH-1:0] o_if_insn,
   output logic                       o_bus_if_halt
);

   localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

   logic [RV32_DATA_WIDTH-1:0] r_pc;
   logic [RV32_DATA_WIDTH-1:0] r_tag_pc;
   logic [RV32_DATA_WIDTH-1:0] r_if_pc;
   logic [RV32_DATA_WIDTH-1:0] r_if_insn;
   logic                       r_if_vld;
   logic                       r_outst;
   logic                       r_drop;
   logic                       r_req_pend;
   logic                       r_started;

   logic                       w_redirect;
   logic [RV32_DATA_WIDTH-1:0] w_target;
   logic                       w_flush;
   logic                       w_stall_pc;
   logic                       w_stall_ifid;
   logic                       w_req;
   logic                       w_grant;
   logic                       w_rsp;
   logic                       w_rsp_keep;
   logic                       w_bypass;
   logic                       w_push;
   logic                       w_pop;
   fetch_entry_t               w_wentry;
   fetch_entry_t               w_head;
   logic [CNT_W-1:0]           w_q_count;
   logic                       w_q_full;
   logic                       w_q_empty;
   logic                       w_unused;

   assign w_redirect   = i_clint_assert | i_x_branch_taken;
   assign w_target     = (i_clint_assert ? i_clint_addr : i_x_branch_target) & ~32'h3;
   assign w_flush      = w_redirect | i_flush_vec[FLUSH_IFID_BIT];
   assign w_stall_pc   = i_stall_vec[STALL_PC_BIT];
   assign w_stall_ifid = i_stall_vec[STALL_IFID_BIT];

   // An ungranted request stays up until granted, except a redirect withdraws it
   assign w_req   = r_started & ~r_outst & ~w_redirect & (r_req_pend | (~w_stall_pc & ~w_q_full));
   assign w_grant = w_req & i_ibus_gnt;

   // Responses with no request outstanding (e.g. straddling a reset) are ignored
   assign w_rsp      = i_ibus_rvalid & r_outst;
   assign w_rsp_keep = w_rsp & ~r_drop & ~w_flush;
   assign w_bypass   = w_rsp_keep & w_q_empty & ~w_stall_ifid;
   assign w_push     = w_rsp_keep & ~w_bypass;
   assign w_pop      = ~w_stall_ifid & ~w_q_empty & ~w_flush;
   assign w_wentry   = {r_tag_pc, i_ibus_rdata};

   ifu_queue #(
      .DEPTH (QUEUE_DEPTH),
      .WIDTH (ENTRY_WIDTH)
   ) u_queue (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_clear (w_flush),
      .i_wdata (w_wentry),
      .o_rdata (w_head),
      .o_count (w_q_count),
      .o_full  (w_q_full),
      .o_empty (w_q_empty)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_started  <= 1'b0;
         r_req_pend <= 1'b0;
         r_pc       <= RESET_PC;
         r_tag_pc   <= '0;
         r_outst    <= 1'b0;
         r_drop     <= 1'b0;
         r_if_vld   <= 1'b0;
         r_if_pc    <= '0;
         r_if_insn  <= NOP_INSN;
      end else begin
         r_started  <= 1'b1;
         r_req_pend <= w_req & ~i_ibus_gnt;

         if (w_redirect)   r_pc <= w_target;
         else if (w_grant) r_pc <= r_pc + 32'd4;

         if (w_grant) begin
            r_outst  <= 1'b1;
            r_tag_pc <= r_pc;
         end else if (w_rsp) begin
            r_outst  <= 1'b0;
         end

         // A response still in flight past a redirect belongs to the old stream
         if (w_redirect)          r_drop <= r_outst & ~i_ibus_rvalid;
         else if (w_rsp && r_drop) r_drop <= 1'b0;

         if (w_flush) begin
            r_if_vld <= 1'b0;
         end else if (!w_stall_ifid) begin
            if (!w_q_empty) begin
               r_if_vld  <= 1'b1;
               r_if_pc   <= w_head.pc;
               r_if_insn <= w_head.insn;
            end else if (w_bypass) begin
               r_if_vld  <= 1'b1;
               r_if_pc   <= r_tag_pc;
               r_if_insn <= i_ibus_rdata;
            end else begin
               r_if_vld  <= 1'b0;
            end
         end
      end
   end

   assign o_ibus_req    = w_req;
   assign o_ibus_addr   = r_pc;
   assign o_if_vld      = r_if_vld;
   assign o_if_pc       = r_if_pc;
   assign o_if_insn     = r_if_vld ? r_if_insn : NOP_INSN;
   assign o_bus_if_halt = w_q_empty & (r_outst | w_req) & ~w_redirect;

   assign w_unused = ^{i_stall_vec, i_flush_vec, w_q_count};

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// ============================================================================
// tb_ifu_fetch : directed scenarios, expected IF/ID stream checked by a monitor
// Rev 1.0
// ============================================================================
module tb_ifu_fetch;
   import ifu_fetch_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  stall_vec = '0;
   logic [1:0]  flush_vec = '0;
   logic        br_taken = 1'b0;
   logic [31:0] br_target = '0;
   logic        clint = 1'b0;
   logic [31:0] clint_addr = '0;
   logic        ibus_req;
   logic [31:0] ibus_addr;
   logic        gnt = 1'b1;
   logic        rvalid = 1'b0;
   logic [31:0] rdata = '0;
   logic        if_vld;
   logic [31:0] if_pc;
   logic [31:0] if_insn;
   logic        halt;

   int          n_tests = 0;
   int          n_fail = 0;
   logic [31:0] sb[$];
   logic [31:0] glog[$];
   int          rlat = 1;
   logic        watch_en = 1'b0;
   logic [31:0] watch_pc = '0;
   int          watch_hits = 0;
   logic [31:0] m_exp;

   logic        b_pend = 1'b0;
   logic [31:0] b_addr = '0;
   int          b_cnt = 0;

   always #5 clk = ~clk;

   ifu_fetch dut (
      .i_clk             (clk),
      .i_rst_n           (rst_n),
      .i_stall_vec       (stall_vec),
      .i_flush_vec       (flush_vec),
      .i_x_branch_taken  (br_taken),
      .i_x_branch_target (br_target),
      .i_clint_assert    (clint),
      .i_clint_addr      (clint_addr),
      .o_ibus_req        (ibus_req),
      .o_ibus_addr       (ibus_addr),
      .i_ibus_gnt        (gnt),
      .i_ibus_rvalid     (rvalid),
      .i_ibus_rdata      (rdata),
      .o_if_vld          (if_vld),
      .o_if_pc           (if_pc),
      .o_if_insn         (if_insn),
      .o_bus_if_halt     (halt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Instruction memory model: word at address A reads back as ~A after rlat cycles
   always begin
      @(negedge clk);
      if (rst_n && ibus_req && gnt) begin
         b_pend = 1'b1;
         b_addr = ibus_addr;
         b_cnt  = rlat;
         glog.push_back(ibus_addr);
      end
      @(posedge clk);
      #1;
      rvalid = 1'b0;
      rdata  = '0;
      if (!rst_n) begin
         b_pend = 1'b0;
      end else if (b_pend) begin
         b_cnt--;
         if (b_cnt == 0) begin
            rvalid = 1'b1;
            rdata  = ~b_addr;
            b_pend = 1'b0;
         end
      end
   end

   // Monitor: each payload taken by decode (not stalled, not flushed) is scored
   always @(negedge clk) begin
      if (rst_n && if_vld) begin
         if (watch_en && if_pc == watch_pc) watch_hits++;
         if (!stall_vec[1] && !flush_vec[1] && !br_taken && !clint && sb.size() > 0) begin
            m_exp = sb.pop_front();
            check("mon_if_pc", if_pc, m_exp);
            check("mon_if_insn", if_insn, ~m_exp);
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   // Leaves the caller at cycle 0: the first cycle with reset released
   task automatic do_reset(input int lat, input logic g);
      rst_n = 1'b0; stall_vec = '0; flush_vec = '0;
      br_taken = 1'b0; br_target = '0; clint = 1'b0; clint_addr = '0;
      gnt = g; rlat = lat; watch_en = 1'b0; watch_hits = 0;
      sb.delete();
      next_cycle();
      next_cycle();
      at_neg();
      check("rst_req",   32'(ibus_req), 32'd0);
      check("rst_addr",  ibus_addr, 32'h0000_0000);
      check("rst_vld",   32'(if_vld), 32'd0);
      check("rst_pc",    if_pc, 32'h0000_0000);
      check("rst_insn",  if_insn, 32'h0000_0013);
      check("rst_halt",  32'(halt), 32'd0);
      next_cycle();
      rst_n = 1'b1;
      glog.delete();
   endtask

   task automatic drain(input string name, input int max);
      int k;
      k = 0;
      while (sb.size() > 0 && k < max) begin
         next_cycle();
         k++;
      end
      check(name, 32'(sb.size()), 32'd0);
   endtask

   initial begin
      logic found;

      // Basic sequential fetch with a zero-wait bus
      do_reset(1, 1'b1);
      sb.push_back(32'h0); sb.push_back(32'h4); sb.push_back(32'h8);
      at_neg();
      check("s1_req_c0", 32'(ibus_req), 32'd0);
      next_cycle(); at_neg();
      check("s1_req_c1", 32'(ibus_req), 32'd1);
      check("s1_addr_c1", ibus_addr, 32'h0);
      check("s1_halt_c1", 32'(halt), 32'd1);
      next_cycle(); at_neg();
      check("s1_vld_c2", 32'(if_vld), 32'd0);
      next_cycle(); at_neg();
      check("s1_vld_c3", 32'(if_vld), 32'd1);
      check("s1_pc_c3", if_pc, 32'h0);
      drain("s1_drain", 40);
      check("s1_glog_len", 32'(glog.size() >= 3), 32'd1);
      check("s1_glog0", glog[0], 32'h0);
      check("s1_glog1", glog[1], 32'h4);
      check("s1_glog2", glog[2], 32'h8);

      // Branch while the 0x8 fetch is in flight: its response must be discarded
      do_reset(3, 1'b1);
      sb.push_back(32'h0); sb.push_back(32'h4); sb.push_back(32'h100); sb.push_back(32'h104);
      watch_en = 1'b1; watch_pc = 32'h8;
      found = 1'b0;
      for (int k = 0; k < 60 && !found; k++) begin
         at_neg();
         if (ibus_req && gnt && ibus_addr == 32'h8) found = 1'b1;
         else next_cycle();
      end
      check("s2_grant8", 32'(found), 32'd1);
      next_cycle();
      br_taken = 1'b1; br_target = 32'h100;
      at_neg();
      check("s2_halt_redirect", 32'(halt), 32'd0);
      check("s2_req_redirect", 32'(ibus_req), 32'd0);
      next_cycle();
      br_taken = 1'b0;
      drain("s2_drain", 60);
      check("s2_no_pc8", 32'(watch_hits), 32'd0);
      watch_en = 1'b0;

      // Trap and branch together: the trap target wins
      do_reset(1, 1'b1);
      sb.push_back(32'h200); sb.push_back(32'h204);
      next_cycle(); next_cycle(); next_cycle();
      clint = 1'b1; clint_addr = 32'h200; br_taken = 1'b1; br_target = 32'h100;
      at_neg();
      check("s3_req_withdrawn", 32'(ibus_req), 32'd0);
      next_cycle();
      clint = 1'b0; br_taken = 1'b0;
      at_neg();
      check("s3_req_n1", 32'(ibus_req), 32'd1);
      check("s3_addr_n1", ibus_addr, 32'h200);
      next_cycle(); at_neg();
      check("s3_vld_n2", 32'(if_vld), 32'd0);
      next_cycle(); at_neg();
      check("s3_vld_n3", 32'(if_vld), 32'd1);
      check("s3_pc_n3", if_pc, 32'h200);
      drain("s3_drain", 40);
      check("s3_glog_len", 32'(glog.size() >= 2), 32'd1);
      check("s3_glog1", glog[1], 32'h200);

      // IF/ID stall for 5 cycles: output holds, queue fills, requests stop
      do_reset(1, 1'b1);
      sb.push_back(32'h0); sb.push_back(32'h4); sb.push_back(32'h8); sb.push_back(32'hC);
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         next_cycle();
         if (if_vld) found = 1'b1;
      end
      check("s4_first_vld", 32'(found), 32'd1);
      stall_vec = 2'b10;
      for (int i = 0; i < 5; i++) begin
         at_neg();
         check("s4_hold_vld", 32'(if_vld), 32'd1);
         check("s4_hold_pc", if_pc, 32'h0);
         check("s4_hold_insn", if_insn, 32'hFFFF_FFFF);
         if (i == 4) begin
            check("s4_req_stopped", 32'(ibus_req), 32'd0);
            check("s4_halt_full", 32'(halt), 32'd0);
            check("s4_grants", 32'(glog.size()), 32'd3);
         end
         next_cycle();
      end
      stall_vec = 2'b00;
      drain("s4_drain", 40);

      // Grant held off for 4 cycles with an empty queue
      do_reset(1, 1'b0);
      sb.push_back(32'h0); sb.push_back(32'h4);
      next_cycle();
      for (int i = 0; i < 4; i++) begin
         at_neg();
         check("s5_halt", 32'(halt), 32'd1);
         check("s5_req", 32'(ibus_req), 32'd1);
         check("s5_addr", ibus_addr, 32'h0);
         next_cycle();
      end
      gnt = 1'b1;
      drain("s5_drain", 40);

      // Unaligned target is word-aligned, and the PC wraps past 0xFFFF_FFFC
      do_reset(1, 1'b1);
      sb.push_back(32'hFFFF_FFFC); sb.push_back(32'h0); sb.push_back(32'h4);
      next_cycle(); next_cycle(); next_cycle();
      br_taken = 1'b1; br_target = 32'hFFFF_FFFF;
      next_cycle();
      br_taken = 1'b0;
      at_neg();
      check("s6_addr_aligned", ibus_addr, 32'hFFFF_FFFC);
      drain("s6_drain", 40);
      check("s6_glog_len", 32'(glog.size() >= 3), 32'd1);
      check("s6_glog1", glog[1], 32'hFFFF_FFFC);
      check("s6_glog2", glog[2], 32'h0);

      // IF/ID flush coinciding with rvalid: response dropped, PC keeps advancing
      do_reset(1, 1'b1);
      sb.push_back(32'h4); sb.push_back(32'h8);
      next_cycle(); next_cycle();
      flush_vec = 2'b10;
      at_neg();
      check("s7_halt_flush", 32'(halt), 32'd1);
      next_cycle();
      flush_vec = 2'b00;
      drain("s7_drain", 40);
      check("s7_glog_len", 32'(glog.size() >= 2), 32'd1);
      check("s7_glog1", glog[1], 32'h4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
